// File: rtl/spec_squash_unit.sv
// Speculative slot tracker: tags slots allocated under an unresolved branch, squashes them on kill.
// Optional SPEC_SQUASH_STATS_EN adds kill/resolve/squashed-slot statistics counters.
module spec_squash_unit #(
  parameter int NUM_ENTRIES = 8,
  parameter int IDX_W       = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   branch_pending,
  input  logic                   kill,
  input  logic                   resolve,
  input  logic                   alloc_valid,
  input  logic [IDX_W-1:0]       alloc_idx,
  input  logic                   free_valid,
  input  logic [IDX_W-1:0]       free_idx,
  input  logic                   squash_ack,
  output logic [NUM_ENTRIES-1:0] valid_mask,
  output logic [NUM_ENTRIES-1:0] spec_mask,
  output logic [IDX_W:0]         spec_count,
  output logic                   squash_valid,
  output logic [NUM_ENTRIES-1:0] squash_mask,
  output logic                   alloc_stall,
  output logic                   alloc_err
`ifdef SPEC_SQUASH_STATS_EN
  ,
  output logic [15:0]            kill_count,
  output logic [15:0]            resolve_count,
  output logic [15:0]            squashed_total
`endif
);

  localparam int CNT_W = IDX_W + 1;

  typedef enum logic {IDLE, SQUASH} state_t;
  state_t state;

  logic [NUM_ENTRIES-1:0] free_vec;
  logic [NUM_ENTRIES-1:0] alloc_vec;
  logic [NUM_ENTRIES-1:0] valid_after_free;
  logic [NUM_ENTRIES-1:0] spec_after_free;
  logic [NUM_ENTRIES-1:0] spec_candidate;
  logic                   alloc_req;
  logic                   alloc_hit;
  logic                   accept_kill;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_ENTRIES-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Free is applied before alloc, so a slot released this cycle may be reallocated at once.
  always_comb begin
    free_vec = '0;
    if (free_valid) free_vec[free_idx] = 1'b1;
    valid_after_free = valid_mask & ~free_vec;
    spec_after_free  = spec_mask & ~free_vec;
    alloc_req = alloc_valid && (state == IDLE);
    alloc_hit = alloc_req && valid_after_free[alloc_idx];
    alloc_vec = '0;
    if (alloc_req && !valid_after_free[alloc_idx]) alloc_vec[alloc_idx] = 1'b1;
    spec_candidate = spec_after_free | (branch_pending ? alloc_vec : '0);
    accept_kill = (state == IDLE) && kill;
  end

  assign spec_count  = popcount(spec_mask);
  assign alloc_stall = (state == SQUASH);

  // Kill captures the speculative set as it would have stood after this edge, then drops it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      valid_mask   <= '0;
      spec_mask    <= '0;
      squash_valid <= 1'b0;
      squash_mask  <= '0;
      alloc_err    <= 1'b0;
    end else begin
      alloc_err <= alloc_hit;
      case (state)
        IDLE: begin
          if (kill) begin
            state        <= SQUASH;
            squash_valid <= 1'b1;
            squash_mask  <= spec_candidate;
            valid_mask   <= (valid_after_free | alloc_vec) & ~spec_candidate;
            spec_mask    <= '0;
          end else if (resolve) begin
            valid_mask <= valid_after_free | alloc_vec;
            spec_mask  <= '0;
          end else begin
            valid_mask <= valid_after_free | alloc_vec;
            spec_mask  <= spec_candidate;
          end
        end
        SQUASH: begin
          valid_mask <= valid_after_free;
          spec_mask  <= spec_after_free;
          if (squash_ack) begin
            state        <= IDLE;
            squash_valid <= 1'b0;
            squash_mask  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPEC_SQUASH_STATS_EN
  logic        accept_resolve;
  logic [16:0] squashed_sum;

  assign accept_resolve = (state == IDLE) && resolve && !kill;
  assign squashed_sum   = {1'b0, squashed_total} + 17'(popcount(spec_candidate));

  // All statistics saturate rather than wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      kill_count     <= '0;
      resolve_count  <= '0;
      squashed_total <= '0;
    end else begin
      if (accept_kill) begin
        if (kill_count != 16'hFFFF) kill_count <= kill_count + 16'd1;
        squashed_total <= squashed_sum[16] ? 16'hFFFF : squashed_sum[15:0];
      end
      if (accept_resolve && resolve_count != 16'hFFFF) resolve_count <= resolve_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/spec_squash_unit.md
Name: spec_squash_unit

Overview:
- Consumer end of the branch resolution interface: takes the branch pending, kill and resolve signals and applies them to in-flight instruction slots.
- Tags each slot allocated while a branch is pending as speculative.
- On kill, issues a held squash request naming all speculative slots and stalls allocation until the request is acknowledged; on resolve, clears all speculative tags.
- Sits between the branch resolution logic and the issue/ROB slot allocator.

Parameters:
- NUM_ENTRIES, 8, number of tracked instruction slots (power of two, 2..32)
- IDX_W, 3, slot index width; must equal log2(NUM_ENTRIES)

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- branch_pending  input  1  a branch is unresolved; slots allocated now are speculative
- kill  input  1  branch mispredicted; squash speculative slots (sampled per cycle)
- resolve  input  1  branch correctly predicted; commit speculative tags (sampled per cycle)
- alloc_valid  input  1  allocate slot alloc_idx this cycle
- alloc_idx  input  IDX_W  slot being allocated
- free_valid  input  1  release slot free_idx this cycle
- free_idx  input  IDX_W  slot being released
- squash_ack  input  1  downstream has consumed the squash request
- valid_mask  output  NUM_ENTRIES  occupied slots
- spec_mask  output  NUM_ENTRIES  occupied speculative slots
- spec_count  output  IDX_W+1  popcount of spec_mask
- squash_valid  output  1  squash request pending
- squash_mask  output  NUM_ENTRIES  slots to squash; stable while squash_valid=1
- alloc_stall  output  1  allocator must not allocate
- alloc_err  output  1  one-cycle pulse: allocation to an already-valid slot

Behaviour:
- Reset (async): valid_mask=0, spec_mask=0, squash_mask=0, squash_valid=0, alloc_err=0, FSM=IDLE. spec_count=0 and alloc_stall=0 follow from this.
- FSM states: IDLE and SQUASH.
- IDLE -> SQUASH on kill=1. Next cycle:
  - squash_valid=1.
  - squash_mask = the spec_mask that would have resulted this cycle:
    - includes a speculative allocation made in the same cycle;
    - excludes a slot freed in the same cycle.
  - Those slots are cleared from valid_mask and spec_mask in the same edge.
- kill with no speculative slots: still enter SQUASH with squash_mask=0, so the handshake stays uniform.
- SQUASH -> IDLE on the edge where squash_ack=1. squash_valid drops the next cycle; squash_mask is cleared to 0 on exit.
- SQUASH is minimum one cycle; squash_ack is ignored in IDLE.
- alloc_stall = (state==SQUASH), combinational.
- Allocations presented during SQUASH are ignored; an allocator ignoring alloc_stall is a protocol error.
- resolve=1 (IDLE): spec_mask cleared to 0 at the edge. An allocation in the same cycle is non-speculative, even though branch_pending is still 1.
- kill and resolve together: kill wins; resolve is ignored.
- kill or resolve during SQUASH: ignored.
- Allocation in IDLE: valid_mask[alloc_idx]=1; spec bit = branch_pending & ~resolve & ~kill, except when the same-cycle kill captures the slot into squash_mask (see kill rule).
- Allocation to an already-valid slot: no state change; alloc_err pulses 1 on the next cycle. A slot freed in the same cycle counts as free (free before alloc).
- Free of slot i: valid_mask[i]=0 and spec_mask[i]=0. Freeing an invalid slot is a no-op.
- All state updates land on the rising edge; outputs are registered except spec_count and alloc_stall.
- Reset mid-SQUASH: immediate return to the reset values above; no ack is required.

Optional Feature:
- SPEC_SQUASH_STATS_EN.
- Defined: adds outputs kill_count [15:0] and resolve_count [15:0].
  - Each increments on an accepted kill or resolve (IDLE only; kill wins on tie).
  - Saturating at 16'hFFFF; async reset to 0.
  - Adds output squashed_total [15:0], saturating, which accumulates popcount(squash_mask) on each SQUASH entry.
- Undefined: these ports and counters do not exist.

Test Plan:
- Speculative alloc then resolve:
  - Stimulus: branch_pending=1; alloc slots 2, 3; then resolve=1.
  - Response: spec_mask=8'h0C, spec_count=2; next cycle spec_mask=0, valid_mask=8'h0C, no squash.
- Kill with same-cycle alloc and free:
  - Stimulus: valid slots 0 (non-spec), 1, 4 (spec); kill with alloc slot 5 and free slot 4 in the same cycle.
  - Response: next cycle squash_valid=1, squash_mask=8'h22, valid_mask=8'h01, alloc_stall=1.
- Squash hold:
  - Stimulus: keep squash_ack=0 for 3 cycles; attempt alloc slot 6; then ack.
  - Response: squash_mask stays 8'h22; slot 6 not allocated; squash_valid=0 and alloc_stall=0 the cycle after ack.
- Kill with resolve:
  - Stimulus: spec slot 7; kill=1 and resolve=1 together.
  - Response: squash_mask=8'h80; resolve has no effect.
- Double alloc:
  - Stimulus: alloc slot 1 twice.
  - Response: alloc_err pulses once; masks unchanged. Alloc and free of slot 1 in the same cycle -> no error, slot 1 stays valid.
- Reset mid-SQUASH:
  - Stimulus: assert reset while squash_valid=1.
  - Response: all outputs 0 immediately; with SPEC_SQUASH_STATS_EN, counters also read 0.
